// File: rtl/qbus_dma_arb.sv
// rtl/qbus_dma_arb.sv - QBUS DMA bus arbiter with grant/hold watchdog
//
// Arbitrates NREQ local DMA requesters for QBUS mastership. It requests the
// bus from the CPU (DMR), waits for the CPU grant (DMGO) and an idle bus
// (SYNC and RPLY both negated), then acknowledges (SACK) and grants one
// requester until that requester signals end of tenure. A 16-bit watchdog
// aborts a stuck request phase or a stuck tenure and sets a sticky error.
//
// Optional feature: define CONFIG_QBUS_ARB_RR_EN for round-robin winner
// selection; left undefined, the lowest requesting index always wins.
//
// Parameters:
//   NREQ        number of requesters (2..8)
//   TOUT        watchdog limit in clocks (15..65535)
// Ports:
//   pin_clk     in   block clock, rising edge
//   pin_dclo_n  in   asynchronous active-low reset
//   dma_req     in   [NREQ] per-requester request level
//   dma_done    in   [NREQ] per-requester end-of-tenure pulse
//   dma_gnt     out  [NREQ] one-hot grant
//   pin_dmr_n   out  bus request to CPU, active-low
//   pin_dmgo_n  in   bus grant from CPU, active-low
//   pin_sack_n  out  grant acknowledge to CPU, active-low
//   pin_sync_n  in   QBUS SYNC strobe, active-low
//   pin_rply_n  in   QBUS RPLY strobe, active-low
//   arb_err     out  sticky watchdog fault flag
module qbus_dma_arb #(
  parameter int NREQ = 4,
  parameter int TOUT = 255
) (
  input  logic            pin_clk,
  input  logic            pin_dclo_n,
  input  logic [NREQ-1:0] dma_req,
  input  logic [NREQ-1:0] dma_done,
  output logic [NREQ-1:0] dma_gnt,
  output logic            pin_dmr_n,
  input  logic            pin_dmgo_n,
  output logic            pin_sack_n,
  input  logic            pin_sync_n,
  input  logic            pin_rply_n,
  output logic            arb_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] TOUT16 = 16'(TOUT);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_ACK  = 3'd3,
    ST_HOLD = 3'd4,
    ST_REL  = 3'd5
  } state_t;

  state_t          state;
  logic [15:0]     cnt;
  logic [15:0]     cnt_inc;
  logic [NREQ-1:0] req_q;
  logic [IW-1:0]   win;
  logic [IW-1:0]   pick;
  logic            found;
  int              idx;

`ifdef CONFIG_QBUS_ARB_RR_EN
  logic [IW-1:0]   ptr;
`endif

  assign cnt_inc = cnt + 16'd1;

  // Winner search over the registered request vector. Round-robin starts
  // one past the previous winner and wraps; fixed priority starts at 0.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef CONFIG_QBUS_ARB_RR_EN
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
`else
      idx = i;
`endif
      if (!found && req_q[IW'(idx)]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  // Requests are registered once before the FSM sees them, so arbitration
  // and the winner latch always work from a stable vector. This stage is
  // what puts the first grant on the fourth edge after a request rises.
  always_ff @(posedge pin_clk or negedge pin_dclo_n) begin
    if (!pin_dclo_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      req_q      <= '0;
      win        <= '0;
      dma_gnt    <= '0;
      pin_dmr_n  <= 1'b1;
      pin_sack_n <= 1'b1;
      arb_err    <= 1'b0;
`ifdef CONFIG_QBUS_ARB_RR_EN
      ptr        <= '0;
`endif
    end else begin
      req_q <= dma_req;
      case (state)
        ST_IDLE: begin
          if (|req_q) begin
            state     <= ST_REQ;
            cnt       <= '0;
            pin_dmr_n <= 1'b0;
          end
        end

        ST_REQ: begin
          if (!(|req_q)) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pin_dmr_n <= 1'b1;
          end else if (!pin_dmgo_n) begin
            state <= ST_WAIT;
            cnt   <= '0;
          end else if (cnt_inc == TOUT16) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pin_dmr_n <= 1'b1;
            arb_err   <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_WAIT: begin
          if (!found) begin
            // Everyone withdrew after the CPU granted; give the bus back.
            state     <= ST_IDLE;
            cnt       <= '0;
            pin_dmr_n <= 1'b1;
          end else if (pin_sync_n && pin_rply_n) begin
            state      <= ST_ACK;
            cnt        <= '0;
            win        <= pick;
            dma_gnt    <= NREQ'(1) << pick;
            pin_sack_n <= 1'b0;
            pin_dmr_n  <= 1'b1;
`ifdef CONFIG_QBUS_ARB_RR_EN
            ptr <= (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
`endif
          end
        end

        ST_ACK: begin
          state <= ST_HOLD;
          cnt   <= '0;
        end

        ST_HOLD: begin
          // Done is checked before the watchdog so a completion on the
          // expiry clock ends the tenure cleanly without an error.
          if (dma_done[win]) begin
            state      <= ST_REL;
            cnt        <= '0;
            dma_gnt    <= '0;
            pin_sack_n <= 1'b1;
          end else if (cnt_inc == TOUT16) begin
            state      <= ST_REL;
            cnt        <= '0;
            dma_gnt    <= '0;
            pin_sack_n <= 1'b1;
            arb_err    <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_REL: begin
          cnt <= '0;
          if (|req_q) begin
            state     <= ST_REQ;
            pin_dmr_n <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state      <= ST_IDLE;
          cnt        <= '0;
          dma_gnt    <= '0;
          pin_dmr_n  <= 1'b1;
          pin_sack_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qbus_dma_arb.sv
// tb/tb_qbus_dma_arb.sv - directed self-checking bench for qbus_dma_arb
module tb_qbus_dma_arb;

  logic       pin_clk;
  logic       pin_dclo_n;
  logic [3:0] dma_req;
  logic [3:0] dma_done;
  logic [3:0] dma_gnt;
  logic       pin_dmr_n;
  logic       pin_dmgo_n;
  logic       pin_sack_n;
  logic       pin_sync_n;
  logic       pin_rply_n;
  logic       arb_err;

  int n_checks;
  int n_errors;

  qbus_dma_arb #(.NREQ(4), .TOUT(15)) dut (
    .pin_clk    (pin_clk),
    .pin_dclo_n (pin_dclo_n),
    .dma_req    (dma_req),
    .dma_done   (dma_done),
    .dma_gnt    (dma_gnt),
    .pin_dmr_n  (pin_dmr_n),
    .pin_dmgo_n (pin_dmgo_n),
    .pin_sack_n (pin_sack_n),
    .pin_sync_n (pin_sync_n),
    .pin_rply_n (pin_rply_n),
    .arb_err    (arb_err)
  );

  initial pin_clk = 1'b0;
  always #5 pin_clk = ~pin_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pin_clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    pin_dclo_n = 1'b0;
    dma_req    = 4'b0000;
    dma_done   = 4'b0000;
    pin_dmgo_n = 1'b0;
    pin_sync_n = 1'b1;
    pin_rply_n = 1'b1;
    step(2);
    pin_dclo_n = 1'b1;
  endtask

  // Waits (bounded) for a grant in ACK, then ends the tenure from HOLD.
  task automatic grant_and_done(input string tag, input logic [3:0] exp);
    int k;
    logic [3:0] g;
    k = 0;
    while (dma_gnt == 4'b0000 && k < 20) begin
      step(1);
      k++;
    end
    g = dma_gnt;
    check(tag, 32'(g), 32'(exp));
    step(1);
    dma_done = g;
    step(1);
    dma_done = 4'b0000;
    check({tag, "_rel"}, 32'(dma_gnt), 32'h0);
  endtask

  logic [3:0] exp_second;

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset state
    apply_reset();
    check("rst_gnt",  32'(dma_gnt),    32'h0);
    check("rst_dmr",  32'(pin_dmr_n),  32'h1);
    check("rst_sack", 32'(pin_sack_n), 32'h1);
    check("rst_err",  32'(arb_err),    32'h0);

    // Single requester, latency and release
    step(1);
    dma_req = 4'b0001;
    step(1);
    check("lat_e1_dmr", 32'(pin_dmr_n), 32'h1);
    step(1);
    check("lat_e2_dmr", 32'(pin_dmr_n), 32'h0);
    step(1);
    check("lat_e3_gnt", 32'(dma_gnt), 32'h0);
    step(1);
    check("lat_e4_gnt",  32'(dma_gnt),    32'h1);
    check("lat_e4_sack", 32'(pin_sack_n), 32'h0);
    check("lat_e4_dmr",  32'(pin_dmr_n),  32'h1);
    step(1);
    check("hold_gnt", 32'(dma_gnt), 32'h1);
    dma_done = 4'b0100;
    step(1);
    check("foreign_done_ignored", 32'(dma_gnt), 32'h1);
    dma_done = 4'b0001;
    dma_req  = 4'b0000;
    step(1);
    dma_done = 4'b0000;
    check("rel_gnt",  32'(dma_gnt),    32'h0);
    check("rel_sack", 32'(pin_sack_n), 32'h1);
    step(1);
    check("idle_dmr", 32'(pin_dmr_n), 32'h1);
    step(2);
    check("idle_stay_dmr", 32'(pin_dmr_n), 32'h1);
    check("idle_stay_gnt", 32'(dma_gnt),   32'h0);

    // Arbitration order with two requesters held
    apply_reset();
`ifdef CONFIG_QBUS_ARB_RR_EN
    exp_second = 4'b0100;
`else
    exp_second = 4'b0001;
`endif
    step(1);
    dma_req = 4'b0101;
    grant_and_done("order_1", 4'b0001);
    grant_and_done("order_2", exp_second);
    grant_and_done("order_3", 4'b0001);
    dma_req = 4'b0000;
    step(4);
    check("order_idle_dmr", 32'(pin_dmr_n), 32'h1);

    // Bus busy in WAIT
    apply_reset();
    step(1);
    pin_sync_n = 1'b0;
    dma_req    = 4'b0010;
    step(3);
    step(10);
    check("busy_sync_gnt", 32'(dma_gnt), 32'h0);
    pin_sync_n = 1'b1;
    pin_rply_n = 1'b0;
    step(2);
    check("busy_rply_gnt", 32'(dma_gnt), 32'h0);
    pin_rply_n = 1'b1;
    step(1);
    check("busy_release_gnt", 32'(dma_gnt), 32'h2);
    step(1);
    dma_req  = 4'b0000;
    dma_done = 4'b0010;
    step(1);
    dma_done = 4'b0000;
    check("busy_rel_gnt", 32'(dma_gnt), 32'h0);

    // Request withdrawn before CPU grant
    apply_reset();
    pin_dmgo_n = 1'b1;
    step(1);
    dma_req = 4'b0001;
    step(2);
    check("drop_dmr_low", 32'(pin_dmr_n), 32'h0);
    dma_req = 4'b0000;
    step(2);
    check("drop_dmr_high", 32'(pin_dmr_n), 32'h1);
    check("drop_err",      32'(arb_err),   32'h0);

    // Watchdog in REQ
    apply_reset();
    pin_dmgo_n = 1'b1;
    step(1);
    dma_req = 4'b0001;
    step(16);
    check("wd_req_e16_err", 32'(arb_err),   32'h0);
    check("wd_req_e16_dmr", 32'(pin_dmr_n), 32'h0);
    dma_req = 4'b0000;
    step(1);
    check("wd_req_err", 32'(arb_err),   32'h1);
    check("wd_req_dmr", 32'(pin_dmr_n), 32'h1);
    step(2);
    check("wd_req_sticky", 32'(arb_err), 32'h1);

    // Watchdog in HOLD, DMGO negation ignored during tenure
    apply_reset();
    step(1);
    dma_req = 4'b0001;
    step(6);
    pin_dmgo_n = 1'b1;
    step(13);
    check("wd_hold_e19_gnt", 32'(dma_gnt), 32'h1);
    check("wd_hold_e19_err", 32'(arb_err), 32'h0);
    dma_req    = 4'b0000;
    pin_dmgo_n = 1'b0;
    step(1);
    check("wd_hold_gnt",  32'(dma_gnt),    32'h0);
    check("wd_hold_sack", 32'(pin_sack_n), 32'h1);
    check("wd_hold_err",  32'(arb_err),    32'h1);

    // Done on the expiry clock wins
    apply_reset();
    step(1);
    dma_req = 4'b0001;
    step(19);
    dma_req  = 4'b0000;
    dma_done = 4'b0001;
    step(1);
    dma_done = 4'b0000;
    check("wd_done_gnt", 32'(dma_gnt), 32'h0);
    check("wd_done_err", 32'(arb_err), 32'h0);

    // Reset during HOLD
    apply_reset();
    step(1);
    dma_req = 4'b0001;
    step(5);
    check("rst_hold_pre_gnt", 32'(dma_gnt), 32'h1);
    dma_req    = 4'b0000;
    pin_dclo_n = 1'b0;
    #1;
    check("rst_hold_gnt",  32'(dma_gnt),    32'h0);
    check("rst_hold_sack", 32'(pin_sack_n), 32'h1);
    check("rst_hold_err",  32'(arb_err),    32'h0);
    step(1);
    pin_dclo_n = 1'b1;
    step(2);
    check("rst_hold_after_gnt", 32'(dma_gnt),   32'h0);
    check("rst_hold_after_dmr", 32'(pin_dmr_n), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/qbus_dma_arb.md
QBUS_DMA_ARB -- requirements
Module: qbus_dma_arb

Interface
REQ-001 Parameter NREQ, default 4: number of DMA requesters, range 2..8.
REQ-002 Parameter TOUT, default 255: grant/hold watchdog limit in clocks, range 15..65535.
REQ-003 pin_clk  in  1  single block clock; all state changes on rising edge.
REQ-004 pin_dclo_n  in  1  asynchronous active-low reset.
REQ-005 dma_req  in  NREQ  per-requester bus request, active-high level.
REQ-006 dma_done  in  NREQ  per-requester end-of-tenure pulse, active-high, one clock.
REQ-007 dma_gnt  out  NREQ  one-hot bus grant, active-high.
REQ-008 pin_dmr_n  out  1  bus request to CPU, active-low.
REQ-009 pin_dmgo_n  in  1  bus grant from CPU, active-low.
REQ-010 pin_sack_n  out  1  grant acknowledge to CPU, active-low.
REQ-011 pin_sync_n, pin_rply_n  in  1 each  QBUS strobes, active-low, used for bus-idle detection.
REQ-012 arb_err  out  1  watchdog fault flag, sticky until next reset.

Function
REQ-013 FSM states: IDLE, REQ, WAIT, ACK, HOLD, REL; exactly one state active.
REQ-014 IDLE: if any dma_req set -> REQ next clock, pin_dmr_n driven low in REQ.
REQ-015 REQ: pin_dmgo_n sampled low -> WAIT; all dma_req dropped before grant -> IDLE, pin_dmr_n high.
REQ-016 WAIT: go to ACK only on a clock where pin_sync_n=1 and pin_rply_n=1 (bus idle).
REQ-017 Winner latched on the WAIT->ACK transition; later dma_req changes do not alter it during tenure.
REQ-018 ACK: pin_sack_n low, pin_dmr_n high, dma_gnt[winner]=1; single clock, then HOLD.
REQ-019 HOLD: pin_sack_n and dma_gnt stay asserted until dma_done[winner]=1, then REL.
REQ-020 dma_done on a non-winner index is ignored in every state.
REQ-021 REL: pin_sack_n high, dma_gnt all zero for exactly one clock; then REQ if any dma_req set, else IDLE.
REQ-022 Latency: dma_req rising in IDLE with dmgo_n already low and bus idle -> dma_gnt set on 4th rising edge after dma_req set (IDLE->REQ->WAIT->ACK).
REQ-023 Watchdog counter 16 bits, cleared on every state entry, counts in REQ and HOLD only.
REQ-024 Counter reaches TOUT in REQ -> arb_err=1, pin_dmr_n high, go to IDLE.
REQ-025 Counter reaches TOUT in HOLD -> arb_err=1, force REL (grant revoked).
REQ-026 dma_done and watchdog expiry on same HOLD clock -> done wins, arb_err unchanged.
REQ-027 pin_dmgo_n rising during HOLD does not end the tenure; only done or watchdog does.
REQ-028 dma_gnt never has more than one bit set; pin_sack_n low iff state is ACK or HOLD.

Reset
REQ-029 pin_dclo_n low asynchronously forces IDLE, counter 0, arb_err 0, dma_gnt 0, pin_dmr_n 1, pin_sack_n 1, round-robin pointer 0.
REQ-030 Reset mid-tenure drops grant and sack in the same instant; no REL cycle is generated.
REQ-031 Reset release synchronous: first state evaluation on the first rising edge with pin_dclo_n high.

Configuration
REQ-032 Macro CONFIG_QBUS_ARB_RR_EN defined: round-robin; search starts at index (last winner+1) mod NREQ, wrapping.
REQ-033 Macro undefined: fixed priority, lowest index wins; pointer logic not compiled.

Verification
REQ-034 dma_req=0001, dmgo_n tied low, bus idle -> dma_gnt=0001 and sack_n low on 4th edge; done pulse -> one REL clock, then IDLE, dmr_n high.
REQ-035 dma_req=0101 held, done after each grant, RR_EN defined -> grant order 0001,0100,0001; undefined -> 0001,0001,0001.
REQ-036 pin_sync_n held low 10 clocks in WAIT -> no grant until clock after sync_n rises with rply_n high.
REQ-037 TOUT=15, dmgo_n never asserted -> arb_err=1 after 15 REQ clocks, dmr_n high, state IDLE.
REQ-038 TOUT=15, winner never pulses done -> grant revoked after 15 HOLD clocks, arb_err=1; done on expiry clock -> arb_err stays 0.
REQ-039 pin_dclo_n pulsed low during HOLD -> dma_gnt=0, sack_n=1 immediately, no REL clock, arb_err=0.
